// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM encoding
// and default PC sequencing constants.
package fetch_prefetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int unsigned FETCH_RESET_PC = 0;
    localparam int unsigned FETCH_PC_STEP  = 4;

endpackage

// File: rtl/fetch_prefetch_unit_fifo.sv
// Synchronous prefetch queue holding {pc, instr} pairs; clear wins over
// push/pop and the head reads as zero while the queue is empty.
module fetch_prefetch_unit_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: pointers and level decide what is visible.
    always_ff @(posedge clk) begin
        if (push && !clear && !rst) mem[wr_ptr] <= din;
    end

    assign head = (level != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: sequential PC generation, single-outstanding
// memory reads, redirect with flush, and a prefetch queue toward decode.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int          PC_WIDTH = 32,
    parameter int          IWIDTH   = 32,
    parameter int          DEPTH    = 4,
    parameter int unsigned RESET_PC = FETCH_RESET_PC,
    parameter int unsigned PC_STEP  = FETCH_PC_STEP
) (
    input  logic                      f_clk,
    input  logic                      f_rst,
    input  logic                      f_i_ce,
    input  logic                      f_i_redirect,
    input  logic [PC_WIDTH-1:0]       f_i_target,
    output logic                      f_o_req,
    output logic [PC_WIDTH-1:0]       f_o_addr,
    input  logic                      f_i_ack,
    input  logic [IWIDTH-1:0]         f_i_instr,
    output logic                      f_o_valid,
    output logic [IWIDTH-1:0]         f_o_instr,
    output logic [PC_WIDTH-1:0]       f_o_pc,
    input  logic                      f_i_ready,
    output logic [$clog2(DEPTH):0]    f_o_level
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] STEP   = PC_WIDTH'(PC_STEP);

    fetch_state_t          state;
    logic [PC_WIDTH-1:0]   next_pc;
    logic [PC_WIDTH-1:0]   pc_inc;
    logic [PC_WIDTH-1:0]   target_al;
    logic                  push;
    logic                  pop;
    logic [LW:0]           level_next;
    logic                  room;
    logic [PC_WIDTH+IWIDTH-1:0] head;

    assign target_al  = f_i_target & ~PC_WIDTH'(3);
    assign pc_inc     = next_pc + STEP;
    assign push       = (state == REQ) && f_i_ack;
    assign pop        = f_o_valid && f_i_ready;

    // A new request is only issued when a slot is guaranteed after this edge,
    // so the queue can never overflow.
    assign level_next = (LW+1)'(f_o_level) + (LW+1)'(push) - (LW+1)'(pop);
    assign room       = level_next < (LW+1)'(DEPTH);

    always_ff @(posedge f_clk) begin
        if (f_rst) begin
            state    <= IDLE;
            f_o_req  <= 1'b0;
            f_o_addr <= RST_PC;
            next_pc  <= RST_PC;
        end else if (f_i_redirect) begin
            next_pc <= target_al;
            // The in-flight read must still be retired; its data is dropped.
            if ((state == REQ || state == DRAIN) && !f_i_ack) begin
                state <= DRAIN;
            end else begin
                state   <= IDLE;
                f_o_req <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (f_i_ce && room) begin
                        state    <= REQ;
                        f_o_req  <= 1'b1;
                        f_o_addr <= next_pc;
                    end
                end
                REQ: begin
                    if (f_i_ack) begin
                        next_pc <= pc_inc;
                        if (f_i_ce && room) begin
                            f_o_addr <= pc_inc;
                        end else begin
                            state   <= IDLE;
                            f_o_req <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (f_i_ack) begin
                        state   <= IDLE;
                        f_o_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    f_o_req <= 1'b0;
                end
            endcase
        end
    end

    fetch_prefetch_unit_fifo #(
        .WIDTH (PC_WIDTH + IWIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (f_clk),
        .rst   (f_rst),
        .push  (push),
        .pop   (pop),
        .clear (f_i_redirect),
        .din   ({f_o_addr, f_i_instr}),
        .head  (head),
        .level (f_o_level)
    );

    assign f_o_valid = (f_o_level != '0);
    assign f_o_pc    = head[PC_WIDTH+IWIDTH-1:IWIDTH];
    assign f_o_instr = head[IWIDTH-1:0];

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed and randomized checks of fetch_prefetch_unit against an in-bench
// memory responder and an in-order PC-stream scoreboard.
module tb_fetch_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst, ce, redirect, ack, ready;
    logic [31:0] target, minstr;
    logic        req, valid;
    logic [31:0] addr, oinstr, opc;
    logic [2:0]  level;

    logic        rst8, ce8, redirect8, ack8, ready8;
    logic [7:0]  target8;
    logic [31:0] minstr8;
    logic        req8, valid8;
    logic [7:0]  addr8, opc8;
    logic [31:0] oinstr8;
    logic [2:0]  level8;

    int ncmp = 0;
    int nfail = 0;

    // memory responder and scoreboard state
    bit          mem_on = 1'b1;
    bit          rand_lat = 1'b0;
    bit          sb_on = 1'b0;
    int          lat = 0;
    int          wcnt = 0;
    logic [31:0] exp_pc = '0;
    int          npop = 0;

    always #5 clk = ~clk;

    fetch_prefetch_unit #(
        .PC_WIDTH(32), .IWIDTH(32), .DEPTH(4), .RESET_PC(0), .PC_STEP(4)
    ) dut (
        .f_clk(clk), .f_rst(rst), .f_i_ce(ce), .f_i_redirect(redirect),
        .f_i_target(target), .f_o_req(req), .f_o_addr(addr), .f_i_ack(ack),
        .f_i_instr(minstr), .f_o_valid(valid), .f_o_instr(oinstr),
        .f_o_pc(opc), .f_i_ready(ready), .f_o_level(level)
    );

    fetch_prefetch_unit #(
        .PC_WIDTH(8), .IWIDTH(32), .DEPTH(4), .RESET_PC(32'hFC), .PC_STEP(4)
    ) dut8 (
        .f_clk(clk), .f_rst(rst8), .f_i_ce(ce8), .f_i_redirect(redirect8),
        .f_i_target(target8), .f_o_req(req8), .f_o_addr(addr8), .f_i_ack(ack8),
        .f_i_instr(minstr8), .f_o_valid(valid8), .f_o_instr(oinstr8),
        .f_o_pc(opc8), .f_i_ready(ready8), .f_o_level(level8)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: pre-edge scoreboard, edge, then memory response for next cycle.
    task automatic cyc();
        bit          hold;
        logic [31:0] hold_addr;
        hold = 1'b0;
        hold_addr = addr;
        if (sb_on) begin
            if (valid && ready) begin
                chk("sb_pc", opc, exp_pc);
                chk("sb_instr", oinstr, mem_data(exp_pc));
                exp_pc += 32'd4;
                npop++;
            end
            if (redirect) exp_pc = target & ~32'd3;
            hold = req && !ack;
        end
        @(posedge clk);
        #1;
        if (sb_on) begin
            if (hold) begin
                chk("hold_req", req, 1);
                chk("hold_addr", addr, hold_addr);
            end
            chk("level_max", level <= 3'd4, 1);
            chk("valid_vs_level", valid, level != 3'd0);
            if (!valid) chk("empty_head_zero", {opc, oinstr}, 0);
        end
        if (mem_on) begin
            if (ack || !req) wcnt = 0;
            if (req) begin
                if (wcnt == 0 && rand_lat) lat = int'($urandom_range(0, 3));
                ack = (wcnt >= lat);
                wcnt++;
            end else begin
                ack = 1'b0;
            end
            minstr = mem_data(addr);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ack = 1'b0;
        wcnt = 0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        bit saw_valid;
        rst = 1'b1; ce = 1'b1; redirect = 1'b0; target = '0; ack = 1'b0;
        minstr = '0; ready = 1'b1;
        rst8 = 1'b1; ce8 = 1'b0; redirect8 = 1'b0; target8 = '0; ack8 = 1'b0;
        minstr8 = '0; ready8 = 1'b0;

        // reset values, then zero-wait streaming
        lat = 0;
        cyc(); cyc();
        chk("rst_req", req, 0);
        chk("rst_addr", addr, 0);
        chk("rst_valid", valid, 0);
        chk("rst_instr", oinstr, 0);
        chk("rst_pc", opc, 0);
        chk("rst_level", level, 0);
        rst = 1'b0;
        cyc();
        chk("first_req", req, 1);
        chk("first_addr", addr, 0);
        chk("no_valid_yet", valid, 0);
        cyc();
        chk("first_valid", valid, 1);
        chk("stream_pc0", opc, 0);
        chk("stream_instr0", oinstr, mem_data(0));
        for (int k = 1; k < 4; k++) begin
            cyc();
            chk("stream_pc", opc, 32'(4 * k));
        end
        chk("stream_level", level, 1);

        // decode stall fills the queue exactly
        ready = 1'b0;
        do_reset();
        for (int k = 0; k < 6; k++) cyc();
        chk("full_level", level, 4);
        chk("full_req", req, 0);
        chk("full_head", opc, 0);
        ready = 1'b1;
        cyc();
        chk("resume_req", req, 1);
        chk("resume_addr", addr, 32'h10);
        chk("resume_level", level, 3);
        chk("resume_head", opc, 4);

        // redirect while a slow read is outstanding
        ready = 1'b0;
        lat = 3;
        do_reset();
        for (int k = 0; k < 50 && !(req && addr == 32'h8); k++) cyc();
        chk("wait_req8", req && addr == 32'h8, 1);
        chk("pre_redirect_level", level, 2);
        redirect = 1'b1;
        target = 32'h100;
        cyc();
        redirect = 1'b0;
        chk("drain_level", level, 0);
        chk("drain_req", req, 1);
        chk("drain_addr", addr, 32'h8);
        saw_valid = 1'b0;
        for (int k = 0; k < 30 && !(req && addr == 32'h100); k++) begin
            cyc();
            saw_valid |= valid;
        end
        chk("after_drain_addr", req && addr == 32'h100, 1);
        chk("stale_not_output", saw_valid, 0);
        for (int k = 0; k < 30 && !valid; k++) cyc();
        chk("redirect_first_pc", opc, 32'h100);
        chk("redirect_first_instr", oinstr, mem_data(32'h100));

        // redirect coinciding with ack and pop
        ready = 1'b1;
        lat = 0;
        do_reset();
        for (int k = 0; k < 4; k++) cyc();
        chk("steady_ack", ack && req && valid, 1);
        redirect = 1'b1;
        target = 32'h203;
        cyc();
        redirect = 1'b0;
        chk("redir_ack_level", level, 0);
        chk("redir_ack_valid", valid, 0);
        chk("redir_ack_req", req, 0);
        cyc();
        chk("redir_ack_addr", addr, 32'h200);
        chk("redir_ack_req2", req, 1);

        // fetch-enable drop and 8-bit PC wrap
        rst = 1'b1;
        rst8 = 1'b0;
        ce8 = 1'b1;
        cyc();
        chk("w8_req", req8, 1);
        chk("w8_addr", addr8, 8'hFC);
        ce8 = 1'b0;
        ack8 = 1'b1;
        minstr8 = 32'hDEADBEEF;
        cyc();
        ack8 = 1'b0;
        chk("w8_req_drop", req8, 0);
        chk("w8_level", level8, 1);
        chk("w8_head_pc", opc8, 8'hFC);
        chk("w8_head_instr", oinstr8, 32'hDEADBEEF);
        cyc(); cyc();
        chk("w8_no_new_req", req8, 0);
        ce8 = 1'b1;
        cyc();
        chk("w8_wrap_req", req8, 1);
        chk("w8_wrap_addr", addr8, 8'h00);
        chk("w8_level_kept", level8, 1);

        // reset with a request outstanding and two entries queued
        rst = 1'b0;
        ready = 1'b0;
        lat = 3;
        do_reset();
        for (int k = 0; k < 50 && !(req && addr == 32'h8); k++) cyc();
        chk("mid_wait", req && addr == 32'h8 && level == 3'd2, 1);
        rst = 1'b1;
        cyc();
        chk("mid_rst_req", req, 0);
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_instr", oinstr, 0);
        chk("mid_rst_pc", opc, 0);
        chk("mid_rst_level", level, 0);
        mem_on = 1'b0;
        rst = 1'b0;
        ce = 1'b0;
        ack = 1'b1;
        minstr = 32'h12345678;
        cyc();
        ack = 1'b0;
        chk("stray_ack_level", level, 0);
        chk("stray_ack_valid", valid, 0);
        chk("stray_ack_req", req, 0);
        mem_on = 1'b1;

        // randomized traffic against the stream scoreboard
        ce = 1'b1;
        ready = 1'b1;
        rand_lat = 1'b1;
        do_reset();
        exp_pc = '0;
        npop = 0;
        sb_on = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            ce = ($urandom % 8) != 0;
            ready = ($urandom % 4) != 0;
            redirect = ($urandom % 40) == 0;
            target = $urandom;
            cyc();
        end
        redirect = 1'b0;
        sb_on = 1'b0;
        chk("random_progress", npop > 300, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
